// File: rtl/zero_detector_pkg.sv
// Shared state encoding for the zero detector FSM.
package zero_detector_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } zd_state_t;

    localparam zd_state_t ZD_RESET_STATE = S0;

endpackage

// File: rtl/zero_detector.sv
// Mealy detector that flags the first zero following a run of ones.
module zero_detector
    import zero_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x_in,
    output logic y_out
);

    zd_state_t state_q;
    zd_state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ZD_RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // S3 and S2 only track run length; any zero returns to S0.
    always_comb begin
        state_d = ZD_RESET_STATE;
        case (state_q)
            S0:      state_d = x_in ? S1 : S0;
            S1:      state_d = x_in ? S3 : S0;
            S3:      state_d = x_in ? S2 : S0;
            S2:      state_d = x_in ? S2 : S0;
            default: state_d = ZD_RESET_STATE;
        endcase
    end

    assign y_out = (state_q != S0) & ~x_in;

endmodule

// File: tb/tb_zero_detector.sv
// Bench for zero_detector: vector table, hand-written corner sequences and random stimulus.
module tb_zero_detector;

    logic clk;
    logic rst;
    logic x_in;
    logic y_out;

    int checks;
    int passes;
    int onesSeen;

    typedef struct {
        logic rstV;
        logic xV;
        logic expY;
    } vec_t;

    vec_t vecs[18];

    zero_detector dut (
        .clk   (clk),
        .rst   (rst),
        .x_in  (x_in),
        .y_out (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: y is high when a 1 was sampled since the last zero/reset and x is 0.
    function automatic logic modelY();
        return (onesSeen > 0) && (x_in == 1'b0) && (rst == 1'b0);
    endfunction

    task automatic applyStimulus(input logic r, input logic x);
        @(negedge clk);
        rst  = r;
        x_in = x;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) onesSeen = 0;
        else if (x_in) onesSeen = onesSeen + 1;
        else onesSeen = 0;
    endtask

    task automatic checkOutput(input logic expected, input string name);
        checks++;
        if (y_out !== expected) begin
            $display("[TB] FAIL %s: y_out=%b expected %b at t=%0t", name, y_out, expected, $time);
        end else begin
            passes++;
        end
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        onesSeen = 0;
        rst      = 1'b1;
        x_in     = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rstV, vecs[i].xV);
            checkOutput(vecs[i].expY, $sformatf("vec%0d", i));
            advance();
        end

        // Zeros only after reset.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput(1'b0, "zeros_only");
            advance();
        end

        // Unknown input while idle must not raise the flag.
        applyStimulus(1'b0, 1'bx);
        checkOutput(1'b0, "x_in_unknown_s0");
        x_in = 1'b0;
        advance();

        // Mid-run async reset from a long run of ones.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            advance();
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput(1'b1, "long_run_zero");
        #1 rst = 1'b1;
        onesSeen = 0;
        #1 checkOutput(1'b0, "async_rst_drop");
        #1 rst = 1'b0;
        #1 checkOutput(1'b0, "after_rst_release");
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput(1'b0, "post_rst_zeros");
            advance();
        end

        // Intra-cycle glitch while one 1 has been seen.
        applyStimulus(1'b0, 1'b1);
        advance();
        applyStimulus(1'b0, 1'b1);
        checkOutput(1'b0, "glitch_before");
        x_in = 1'b0;
        #1 checkOutput(1'b1, "glitch_pulse");
        #1 x_in = 1'b1;
        #1 checkOutput(1'b0, "glitch_after");
        advance();
        applyStimulus(1'b0, 1'b0);
        checkOutput(1'b1, "glitch_then_zero");
        advance();
        applyStimulus(1'b0, 1'b0);
        checkOutput(1'b0, "glitch_back_idle");
        advance();

        // Random stream with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
            checkOutput(modelY(), "random");
            if ($urandom_range(0, 15) == 0) begin
                #1 rst = 1'b1;
                onesSeen = 0;
                #1 checkOutput(1'b0, "random_async_rst");
                #1 rst = 1'b0;
            end
            advance();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
